// File: rtl/multicycle_control.sv
// multicycle_control: multicycle FSM sequencer for the MIPS-subset CPU.
// Fetch/decode/execute/memory/writeback through one shared memory port with
// a mem_ready handshake, memory timeout trap and retired-instruction counter.
// Optional macro ILLEGAL_TRAP_EN: unrecognised instructions trap instead of
// retiring as a NOP.
module multicycle_control #(
   parameter int MEM_TIMEOUT = 15,
   parameter int COUNT_W     = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [5:0]         opcode,
   input  logic [5:0]         funct,
   input  logic               zero,
   input  logic               mem_ready,
   output logic               mem_read,
   output logic               mem_write,
   output logic               i_or_d,
   output logic               ir_write,
   output logic               pc_write,
   output logic [1:0]         pc_source,
   output logic               alu_src_a,
   output logic [1:0]         alu_src_b,
   output logic [2:0]         alu_command,
   output logic               reg_write,
   output logic [1:0]         reg_dst,
   output logic               mem_to_reg,
   output logic               link_to_pc,
   output logic               instr_done,
   output logic [COUNT_W-1:0] instr_count,
   output logic               trap,
   output logic [3:0]         state
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_EXEC_R   = 4'd2,
      S_EXEC_I   = 4'd3,
      S_ALU_WB   = 4'd4,
      S_I_WB     = 4'd5,
      S_BRANCH   = 4'd6,
      S_JUMP     = 4'd7,
      S_JAL      = 4'd8,
      S_JR       = 4'd9,
      S_MEM_ADDR = 4'd10,
      S_MEM_RD   = 4'd11,
      S_MEM_WB   = 4'd12,
      S_MEM_WR   = 4'd13,
      S_TRAP     = 4'd14
   } state_t;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_XOR = 3'b010;
   localparam logic [2:0] ALU_SLT = 3'b011;

   // Counter only needs to reach MEM_TIMEOUT-1: the limit is detected while
   // the last waiting cycle is in progress.
   localparam int TO_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [TO_W-1:0] TO_LAST = (MEM_TIMEOUT > 0) ? TO_W'(MEM_TIMEOUT - 1) : '0;

   state_t          cur_state, nxt_state;
   logic [TO_W-1:0] to_cnt;
   logic            to_expire;
   logic            wait_state;

   assign state      = cur_state;
   assign to_expire  = (MEM_TIMEOUT > 0) && (to_cnt == TO_LAST);
   assign wait_state = (cur_state == S_FETCH) || (cur_state == S_MEM_RD) ||
                       (cur_state == S_MEM_WR);

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) cur_state <= S_FETCH;
      else       cur_state <= nxt_state;
   end

   // Memory wait counter: restarts on any state change, counts stalled cycles
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                                          to_cnt <= '0;
      else if (nxt_state != cur_state)                    to_cnt <= '0;
      else if ((MEM_TIMEOUT > 0) && wait_state && !mem_ready) to_cnt <= to_cnt + TO_W'(1);
   end

   // Retired-instruction counter, wraps naturally
   always_ff @(posedge clk or posedge reset) begin
      if (reset)           instr_count <= '0;
      else if (instr_done) instr_count <= instr_count + COUNT_W'(1);
   end

   // Next-state and control decode
   always_comb begin
      nxt_state   = cur_state;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      i_or_d      = 1'b0;
      ir_write    = 1'b0;
      pc_write    = 1'b0;
      pc_source   = 2'b00;
      alu_src_a   = 1'b0;
      alu_src_b   = 2'b00;
      alu_command = ALU_ADD;
      reg_write   = 1'b0;
      reg_dst     = 2'b00;
      mem_to_reg  = 1'b0;
      link_to_pc  = 1'b0;
      instr_done  = 1'b0;
      trap        = 1'b0;
      case (cur_state)
         S_FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = 2'b01;
            if (mem_ready) begin
               ir_write  = 1'b1;
               pc_write  = 1'b1;
               nxt_state = S_DECODE;
            end else if (to_expire) nxt_state = S_TRAP;
         end
         S_DECODE: begin
            alu_src_b = 2'b11;
            case (opcode)
               6'h00: begin
                  case (funct)
                     6'h08:               nxt_state = S_JR;
                     6'h20, 6'h22, 6'h2A: nxt_state = S_EXEC_R;
                     default: begin
`ifdef ILLEGAL_TRAP_EN
                        nxt_state = S_TRAP;
`else
                        instr_done = 1'b1;
                        nxt_state  = S_FETCH;
`endif
                     end
                  endcase
               end
               6'h23, 6'h2B: nxt_state = S_MEM_ADDR;
               6'h08, 6'h0E: nxt_state = S_EXEC_I;
               6'h04, 6'h05: nxt_state = S_BRANCH;
               6'h02:        nxt_state = S_JUMP;
               6'h03:        nxt_state = S_JAL;
               default: begin
`ifdef ILLEGAL_TRAP_EN
                  nxt_state = S_TRAP;
`else
                  instr_done = 1'b1;
                  nxt_state  = S_FETCH;
`endif
               end
            endcase
         end
         S_EXEC_R: begin
            alu_src_a = 1'b1;
            case (funct)
               6'h22:   alu_command = ALU_SUB;
               6'h2A:   alu_command = ALU_SLT;
               default: alu_command = ALU_ADD;
            endcase
            nxt_state = S_ALU_WB;
         end
         S_EXEC_I: begin
            alu_src_a   = 1'b1;
            alu_src_b   = 2'b10;
            alu_command = (opcode == 6'h0E) ? ALU_XOR : ALU_ADD;
            nxt_state   = S_I_WB;
         end
         S_ALU_WB: begin
            reg_write  = 1'b1;
            reg_dst    = 2'b01;
            instr_done = 1'b1;
            nxt_state  = S_FETCH;
         end
         S_I_WB: begin
            reg_write  = 1'b1;
            instr_done = 1'b1;
            nxt_state  = S_FETCH;
         end
         S_BRANCH: begin
            alu_src_a   = 1'b1;
            alu_command = ALU_SUB;
            pc_source   = 2'b01;
            pc_write    = (opcode == 6'h05) ? ~zero : zero;
            instr_done  = 1'b1;
            nxt_state   = S_FETCH;
         end
         S_JUMP: begin
            pc_write   = 1'b1;
            pc_source  = 2'b10;
            instr_done = 1'b1;
            nxt_state  = S_FETCH;
         end
         S_JAL: begin
            pc_write   = 1'b1;
            pc_source  = 2'b10;
            reg_write  = 1'b1;
            reg_dst    = 2'b10;
            link_to_pc = 1'b1;
            instr_done = 1'b1;
            nxt_state  = S_FETCH;
         end
         S_JR: begin
            pc_write   = 1'b1;
            pc_source  = 2'b11;
            instr_done = 1'b1;
            nxt_state  = S_FETCH;
         end
         S_MEM_ADDR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            nxt_state = (opcode == 6'h23) ? S_MEM_RD : S_MEM_WR;
         end
         S_MEM_RD: begin
            mem_read = 1'b1;
            i_or_d   = 1'b1;
            if (mem_ready)      nxt_state = S_MEM_WB;
            else if (to_expire) nxt_state = S_TRAP;
         end
         S_MEM_WB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
            instr_done = 1'b1;
            nxt_state  = S_FETCH;
         end
         S_MEM_WR: begin
            mem_write = 1'b1;
            i_or_d    = 1'b1;
            if (mem_ready) begin
               instr_done = 1'b1;
               nxt_state  = S_FETCH;
            end else if (to_expire) nxt_state = S_TRAP;
         end
         S_TRAP: trap = 1'b1;
         default: nxt_state = S_FETCH;
      endcase
   end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Parametrised successor to the single-cycle control path: a multicycle FSM sequencer for the MIPS-subset CPU.
- Drives fetch/decode/execute/memory/writeback over several cycles through one shared memory port with a ready handshake.
- Sits between the instruction register and the datapath muxes, ALU, regfile and memory.
- Adds memory stall, memory timeout trap, and a retired-instruction counter.

Parameters:
MEM_TIMEOUT, 15, max cycles a memory state waits for mem_ready before trapping; 0 = wait forever
COUNT_W, 32, width of instr_count

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
opcode  input  6  IR[31:26]
funct  input  6  IR[5:0]
zero  input  1  ALU zero flag from the current cycle
mem_ready  input  1  memory completes the access this cycle
mem_read  output  1  memory read request
mem_write  output  1  memory write request
i_or_d  output  1  memory address: 0 = PC, 1 = ALUOut
ir_write  output  1  load IR
pc_write  output  1  load PC (already qualified for branches)
pc_source  output  2  00 = ALU (PC+4), 01 = ALUOut (branch target), 10 = jump target, 11 = Da (jr)
alu_src_a  output  1  0 = PC, 1 = Da
alu_src_b  output  2  00 = Db, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm<<2
alu_command  output  3  000 ADD, 001 SUB, 010 XOR, 011 SLT
reg_write  output  1  regfile write enable
reg_dst  output  2  00 = Rt, 01 = Rd, 10 = 31
mem_to_reg  output  1  writeback data: 0 = ALUOut, 1 = MDR
link_to_pc  output  1  writeback data is PC (jal)
instr_done  output  1  one-cycle pulse in the last cycle of every instruction
instr_count  output  COUNT_W  retired instructions
trap  output  1  sticky fault flag
state  output  4  current FSM state, for debug

Behaviour:
- Outputs are combinational from state, plus mem_ready, zero and opcode where noted. Any strobe not listed for a state is 0. Mux selects default to 0.
- Reset, asynchronous: state=FETCH, instr_count=0, trap=0, timeout counter=0. Reset has priority in every state, including mid-access.
- FETCH:
  - mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, ADD.
  - While mem_ready=1: ir_write=1, pc_write=1, pc_source=00, next state DECODE.
  - Otherwise hold in FETCH.
- DECODE, 1 cycle: alu_src_a=0, alu_src_b=11, ADD (branch target captured into ALUOut). Next state by opcode:
  - 0x00 with funct 0x08 -> JR
  - 0x00 with funct 0x20/0x22/0x2A -> EXEC_R
  - 0x23 or 0x2B -> MEM_ADDR
  - 0x08 or 0x0E -> EXEC_I
  - 0x04 or 0x05 -> BRANCH
  - 0x02 -> JUMP
  - 0x03 -> JAL
  - anything else -> ILLEGAL handling (see Optional Feature)
- EXEC_R: alu_src_a=1, alu_src_b=00; command ADD/SUB/SLT for funct 0x20/0x22/0x2A. Next ALU_WB.
- EXEC_I: alu_src_a=1, alu_src_b=10; ADD for 0x08, XOR for 0x0E. Next I_WB.
- ALU_WB: reg_write=1, reg_dst=01, instr_done=1. Next FETCH.
- I_WB: reg_write=1, reg_dst=00, instr_done=1. Next FETCH.
- BRANCH:
  - alu_src_a=1, alu_src_b=00, SUB, pc_source=01, instr_done=1. Next FETCH.
  - pc_write = zero for 0x04, ~zero for 0x05.
- JUMP: pc_write=1, pc_source=10, instr_done=1. Next FETCH.
- JAL: as JUMP, plus reg_write=1, reg_dst=10, link_to_pc=1.
- JR: pc_write=1, pc_source=11, instr_done=1. Next FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, ADD. Next MEM_RD for 0x23, MEM_WR for 0x2B.
- MEM_RD: mem_read=1, i_or_d=1. Hold until mem_ready, then MEM_WB.
- MEM_WB: reg_write=1, reg_dst=00, mem_to_reg=1, instr_done=1. Next FETCH.
- MEM_WR: mem_write=1, i_or_d=1. Hold until mem_ready; on that cycle instr_done=1, next FETCH.
- Minimum latencies (mem_ready=1 on first request):
  - branch/jump/jr: 3 cycles
  - R-type/I-type/sw: 4 cycles
  - lw: 5 cycles
- Timeout:
  - Counter clears on entry to FETCH, MEM_RD and MEM_WR, and increments each cycle waiting without mem_ready.
  - If MEM_TIMEOUT>0 and the counter reaches MEM_TIMEOUT, next state is TRAP.
  - mem_ready in the same cycle as the limit wins: the access completes, no trap.
- TRAP: all strobes 0, trap=1, instr_done=0. Held until reset.
- instr_count: +1 on every instr_done; wraps modulo 2^COUNT_W.

Optional Feature:
ILLEGAL_TRAP_EN
- Defined: an unrecognised opcode/funct in DECODE goes to TRAP, trap=1 next cycle, instruction not counted.
- Undefined: an unrecognised instruction retires as a NOP. DECODE asserts instr_done and returns to FETCH. trap is only set by memory timeout.

Test Plan:
- add $3,$1,$2 (opcode 0x00, funct 0x20), mem_ready=1 -> states FETCH,DECODE,EXEC_R,ALU_WB; reg_write=1 with reg_dst=01 in cycle 4; instr_count 0->1.
- lw (0x23), fetch ready at once, MEM_RD mem_ready delayed 3 cycles -> mem_read/i_or_d=1 held 4 cycles, MEM_WB has mem_to_reg=1, total 8 cycles.
- beq (0x04) with zero=1 -> pc_write=1, pc_source=01 in BRANCH. bne (0x05) with zero=1 -> pc_write=0, instr_done=1.
- jal (0x03) -> pc_write=1, pc_source=10, reg_write=1, reg_dst=10, link_to_pc=1 in cycle 3.
- MEM_TIMEOUT=15, mem_ready held 0 in FETCH -> TRAP entered after 15 waiting cycles, trap=1 sticky; reset clears to FETCH, trap=0, instr_count=0.
- opcode 0x3F: with ILLEGAL_TRAP_EN -> trap=1 after DECODE; without it -> instr_done pulse, back to FETCH, count +1. Reset asserted mid-MEM_WR -> state=FETCH immediately, mem_write=0.
